// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared sizes, limits, lane-vector type and FSM states for the vector memory unit
package vmem_pkg;

    localparam int ADDR_W = 16;
    localparam int VLEN   = 6;
    localparam int LANE_W = 8;

    // Highest register index a scalar / vector request may name.
    localparam logic [3:0] SCALAR_MAX_IDX = 4'd5;
    localparam logic [3:0] VEC_MAX_IDX    = 4'd9;

    typedef logic [VLEN-1:0][LANE_W-1:0] lane_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_LAST,
        WB,
        ST_ISSUE
    } vmem_state_t;

endpackage

// File: rtl/vmem_lane_ctr.sv
// rtl/vmem_lane_ctr.sv - lane counter and per-lane byte address adder
// Ports: clk, rst (sync, active high), clr/inc counter controls,
//        base first byte address, lane current lane index,
//        lane_addr = base + lane (wraps modulo 2^ADDR_W).
module vmem_lane_ctr #(
    parameter int ADDR_W = 16,
    parameter int CTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    output logic [CTR_W-1:0]  lane,
    output logic [ADDR_W-1:0] lane_addr
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane <= '0;
        end else if (inc) begin
            lane <= lane + 1'b1;
        end
    end

    assign lane_addr = base + ADDR_W'(lane);

endmodule

// File: rtl/vector_mem_unit.sv
// rtl/vector_mem_unit.sv - byte-serial vector/scalar load-store unit feeding a register file
// Ports: clk, rst (sync, active high); request: start, is_store, scalar,
//        base_addr, reg_idx, st_data; memory: mem_addr, mem_we, mem_wdata,
//        mem_rdata (one cycle latency); register file: WE3, SFlag, A3, WD3;
//        status: busy, done, err.
module vector_mem_unit
    import vmem_pkg::*;
#(
    parameter int ADDR_W = vmem_pkg::ADDR_W,
    parameter int VLEN   = vmem_pkg::VLEN,
    parameter int LANE_W = vmem_pkg::LANE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          is_store,
    input  logic                          scalar,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [3:0]                    reg_idx,
    input  logic [VLEN-1:0][LANE_W-1:0]   st_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [LANE_W-1:0]             mem_wdata,
    input  logic [LANE_W-1:0]             mem_rdata,
    output logic                          WE3,
    output logic                          SFlag,
    output logic [3:0]                    A3,
    output logic [VLEN-1:0][LANE_W-1:0]   WD3,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int CTR_W = (VLEN > 1) ? $clog2(VLEN) : 1;

    vmem_state_t state;

    logic                        scalar_q;
    logic [ADDR_W-1:0]           base_q;
    logic [3:0]                  idx_q;
    logic [VLEN-1:0][LANE_W-1:0] st_q;
    logic [VLEN-1:0][LANE_W-1:0] lanes_q;
    logic [VLEN-1:0][LANE_W-1:0] lanes_nx;
    logic [VLEN-1:0][LANE_W-1:0] wd_scalar;

    // Set once the final lane has been issued; the issue state then spends
    // one more cycle before moving on (load: lets the read pipeline drain,
    // store: places done one cycle after the last write).
    logic                        issue_done;

    // Two-stage read tracker: p1 = address on the bus, p2 = data on mem_rdata.
    logic                        p1_v, p2_v;
    logic [CTR_W-1:0]            p1_lane, p2_lane;

    logic [CTR_W-1:0]            lane;
    logic [ADDR_W-1:0]           lane_addr;
    logic                        in_issue, at_last, ctr_inc, ctr_clr, illegal;

    assign in_issue = (state == LD_ISSUE) || (state == ST_ISSUE);
    assign at_last  = scalar_q ? (lane == '0) : (lane == CTR_W'(VLEN - 1));
    assign ctr_inc  = in_issue && !issue_done && !at_last;
    assign ctr_clr  = in_issue && issue_done;
    assign illegal  = scalar ? (reg_idx > SCALAR_MAX_IDX) : (reg_idx > VEC_MAX_IDX);
    assign busy     = (state != IDLE);

    vmem_lane_ctr #(
        .ADDR_W (ADDR_W),
        .CTR_W  (CTR_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (ctr_clr),
        .inc       (ctr_inc),
        .base      (base_q),
        .lane      (lane),
        .lane_addr (lane_addr)
    );

    always_comb begin
        lanes_nx = lanes_q;
        if (p2_v) begin
            lanes_nx[p2_lane] = mem_rdata;
        end
        wd_scalar    = '0;
        wd_scalar[0] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scalar_q   <= 1'b0;
            base_q     <= '0;
            idx_q      <= '0;
            st_q       <= '0;
            lanes_q    <= '0;
            issue_done <= 1'b0;
            p1_v       <= 1'b0;
            p2_v       <= 1'b0;
            p1_lane    <= '0;
            p2_lane    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            WE3        <= 1'b0;
            SFlag      <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            WE3     <= 1'b0;
            SFlag   <= 1'b0;
            mem_we  <= 1'b0;
            p1_v    <= 1'b0;
            p2_v    <= p1_v;
            p2_lane <= p1_lane;
            if (p2_v) begin
                lanes_q <= lanes_nx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        scalar_q <= scalar;
                        base_q   <= base_addr;
                        idx_q    <= reg_idx;
                        st_q     <= st_data;
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            state <= is_store ? ST_ISSUE : LD_ISSUE;
                        end
                    end
                end

                LD_ISSUE: begin
                    if (!issue_done) begin
                        mem_addr <= lane_addr;
                        p1_v     <= 1'b1;
                        p1_lane  <= lane;
                        if (at_last) begin
                            issue_done <= 1'b1;
                        end
                    end else begin
                        issue_done <= 1'b0;
                        state      <= LD_LAST;
                    end
                end

                // The last lane's data is on mem_rdata now; merge it on the
                // way into WB rather than through lanes_q.
                LD_LAST: begin
                    WE3   <= 1'b1;
                    done  <= 1'b1;
                    A3    <= idx_q;
                    SFlag <= scalar_q;
                    WD3   <= scalar_q ? wd_scalar : lanes_nx;
                    state <= WB;
                end

                WB: begin
                    state <= IDLE;
                end

                ST_ISSUE: begin
                    if (!issue_done) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= lane_addr;
                        mem_wdata <= st_q[lane];
                        if (at_last) begin
                            issue_done <= 1'b1;
                        end
                    end else begin
                        issue_done <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
